// File: rtl/inf_token_writer.sv
// ----------------------------------------------------------------------------
// inf_token_writer
//
// Write side of the infix-token RAM. Each number or operator token from the
// keypad/entry logic is packed into a {tag[3:0], payload[31:0]} word and
// written to sequential RAM addresses starting at 1. Address 0 is never
// written, so top_addr_inf == 0 means "empty expression".
//
// On commit the block pulses inf_start for START_CYC cycles. It then stays
// busy, refusing further entry, until the instructor raises finish.
//
// Build option: when the PAREN_CHECK_EN macro is defined, the block tracks
// parenthesis depth. It rejects an unbalanced ')' and any '(' that would
// overflow the depth counter. On commit it auto-closes open parentheses in a
// FLUSH phase before starting evaluation.
//
// Ports
//   CLK_1MHz      in   system clock, rising-edge logic
//   RSTN          in   asynchronous active-low reset
//   tok_valid     in   token present on tok_is_op/tok_data
//   tok_ready     out  token can be accepted this cycle
//   tok_is_op     in   1 = operator/paren, 0 = number
//   tok_data      in   number payload or operator code
//   tok_commit    in   close expression and start evaluation
//   tok_clear     in   discard the expression being entered
//   finish        in   evaluation done (from the instructor)
//   en_inf        out  RAM port-A enable
//   we_inf        out  RAM port-A write enable
//   addr_inf      out  RAM port-A address
//   dl_inf        out  RAM port-A write data
//   top_addr_inf  out  address of last written token (0 = empty)
//   inf_start     out  evaluation start strobe
//   busy          out  high while flushing, starting or running
//   full          out  write pointer at the last RAM address
//   err_syntax    out  one-cycle error pulse
// ----------------------------------------------------------------------------
module inf_token_writer #(
    parameter int DWIDTH_inf  = 36,
    parameter int LEN_inf     = 512,
    parameter int LOG_LEN_inf = 9,
`ifdef PAREN_CHECK_EN
    parameter int DEPTH_W     = 4,
`endif
    parameter int START_CYC   = 2
) (
    input  logic                   CLK_1MHz,
    input  logic                   RSTN,
    input  logic                   tok_valid,
    output logic                   tok_ready,
    input  logic                   tok_is_op,
    input  logic [31:0]            tok_data,
    input  logic                   tok_commit,
    input  logic                   tok_clear,
    input  logic                   finish,
    output logic                   en_inf,
    output logic                   we_inf,
    output logic [LOG_LEN_inf-1:0] addr_inf,
    output logic [DWIDTH_inf-1:0]  dl_inf,
    output logic [LOG_LEN_inf-1:0] top_addr_inf,
    output logic                   inf_start,
    output logic                   busy,
    output logic                   full,
    output logic                   err_syntax
);

    localparam logic [LOG_LEN_inf-1:0] PTR_ONE  = LOG_LEN_inf'(1);
    localparam logic [LOG_LEN_inf-1:0] PTR_FULL = LOG_LEN_inf'(LEN_inf - 1);
    localparam logic [7:0]             CNT_LAST = 8'(START_CYC - 1);

`ifdef PAREN_CHECK_EN
    localparam logic [31:0]        OP_LPAREN = 32'h0000_0150;
    localparam logic [31:0]        OP_RPAREN = 32'h0000_0151;
    localparam logic [DEPTH_W-1:0] DEPTH_MAX = '1;
    localparam logic [DEPTH_W-1:0] DEPTH_ONE = DEPTH_W'(1);
`endif

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WR       = 3'd1,
        ST_START    = 3'd2,
        ST_RUN      = 3'd3
`ifdef PAREN_CHECK_EN
        ,
        ST_FLUSH    = 3'd4,
        ST_FLUSH_WR = 3'd5
`endif
    } state_t;

    // Pack a token into a RAM word: tag 1 for operators, 0 for numbers.
    function automatic logic [DWIDTH_inf-1:0] pack_word(input logic is_op,
                                                        input logic [31:0] data);
        pack_word = DWIDTH_inf'({(is_op ? 4'h1 : 4'h0), data});
    endfunction

    state_t                 state_q, state_d;
    logic [LOG_LEN_inf-1:0] wr_ptr_q, wr_ptr_d;
    logic [LOG_LEN_inf-1:0] top_q, top_d;
    logic [LOG_LEN_inf-1:0] addr_q, addr_d;
    logic [DWIDTH_inf-1:0]  dl_q, dl_d;
    logic                   en_q, en_d;
    logic                   we_q, we_d;
    logic                   err_q, err_d;
    logic                   ready_q, ready_d;
    logic                   busy_q, busy_d;
    logic                   full_q, full_d;
    logic                   start_q, start_d;
    logic [7:0]             cnt_q, cnt_d;

`ifdef PAREN_CHECK_EN
    logic [DEPTH_W-1:0]     depth_q, depth_d;
    logic                   is_lparen_s;
    logic                   is_rparen_s;

    assign is_lparen_s = tok_is_op && (tok_data == OP_LPAREN);
    assign is_rparen_s = tok_is_op && (tok_data == OP_RPAREN);
`endif

    // Next-state and next-output logic. All outputs are registered, so the
    // RAM port values settle right after posedge and are stable for a
    // negedge-writing RAM.
    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        top_d    = top_q;
        addr_d   = addr_q;
        dl_d     = dl_q;
        en_d     = 1'b0;
        we_d     = 1'b0;
        err_d    = 1'b0;
        cnt_d    = cnt_q;
`ifdef PAREN_CHECK_EN
        depth_d  = depth_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (tok_clear) begin
                    wr_ptr_d = '0;
                    top_d    = '0;
`ifdef PAREN_CHECK_EN
                    depth_d  = '0;
`endif
                end else if (tok_valid && ready_q) begin
`ifdef PAREN_CHECK_EN
                    if (is_rparen_s && (depth_q == '0)) begin
                        err_d = 1'b1;
                    end else if (is_lparen_s && (depth_q == DEPTH_MAX)) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = ST_WR;
                        en_d    = 1'b1;
                        we_d    = 1'b1;
                        addr_d  = wr_ptr_q + PTR_ONE;
                        dl_d    = pack_word(tok_is_op, tok_data);
                        if (is_lparen_s) begin
                            depth_d = depth_q + DEPTH_ONE;
                        end else if (is_rparen_s) begin
                            depth_d = depth_q - DEPTH_ONE;
                        end else begin
                            depth_d = depth_q;
                        end
                    end
`else
                    state_d = ST_WR;
                    en_d    = 1'b1;
                    we_d    = 1'b1;
                    addr_d  = wr_ptr_q + PTR_ONE;
                    dl_d    = pack_word(tok_is_op, tok_data);
`endif
                end else if (tok_commit) begin
                    // A commit arriving together with an accepted token is
                    // dropped: the branch above wins.
                    if (wr_ptr_q == '0) begin
                        err_d = 1'b1;
`ifdef PAREN_CHECK_EN
                    end else if (depth_q != '0) begin
                        state_d = ST_FLUSH;
`endif
                    end else begin
                        state_d = ST_START;
                        cnt_d   = '0;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WR: begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
                top_d    = wr_ptr_q + PTR_ONE;
                state_d  = ST_IDLE;
            end
`ifdef PAREN_CHECK_EN
            ST_FLUSH: begin
                if (depth_q == '0) begin
                    state_d = ST_START;
                    cnt_d   = '0;
                end else if (wr_ptr_q == PTR_FULL) begin
                    // No room to close the expression: abandon the start.
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_FLUSH_WR;
                    en_d    = 1'b1;
                    we_d    = 1'b1;
                    addr_d  = wr_ptr_q + PTR_ONE;
                    dl_d    = pack_word(1'b1, OP_RPAREN);
                    depth_d = depth_q - DEPTH_ONE;
                end
            end
            ST_FLUSH_WR: begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
                top_d    = wr_ptr_q + PTR_ONE;
                state_d  = ST_FLUSH;
            end
`endif
            ST_START: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_RUN;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_RUN: begin
                if (finish) begin
                    wr_ptr_d = '0;
                    top_d    = '0;
                    state_d  = ST_IDLE;
`ifdef PAREN_CHECK_EN
                    depth_d  = '0;
`endif
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Status outputs are computed from the next state, so the registered
        // copy matches the state the block is actually in.
        full_d  = (wr_ptr_d == PTR_FULL);
        ready_d = (state_d == ST_IDLE) && !full_d;
        start_d = (state_d == ST_START);
        busy_d  = (state_d != ST_IDLE) && (state_d != ST_WR);
    end

    // State and output registers; reset drops everything immediately, so a
    // pending RAM write is abandoned.
    always_ff @(posedge CLK_1MHz or negedge RSTN) begin
        if (!RSTN) begin
            state_q  <= ST_IDLE;
            wr_ptr_q <= '0;
            top_q    <= '0;
            addr_q   <= '0;
            dl_q     <= '0;
            en_q     <= 1'b0;
            we_q     <= 1'b0;
            err_q    <= 1'b0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
            full_q   <= 1'b0;
            start_q  <= 1'b0;
            cnt_q    <= '0;
`ifdef PAREN_CHECK_EN
            depth_q  <= '0;
`endif
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            top_q    <= top_d;
            addr_q   <= addr_d;
            dl_q     <= dl_d;
            en_q     <= en_d;
            we_q     <= we_d;
            err_q    <= err_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
            full_q   <= full_d;
            start_q  <= start_d;
            cnt_q    <= cnt_d;
`ifdef PAREN_CHECK_EN
            depth_q  <= depth_d;
`endif
        end
    end

    assign tok_ready    = ready_q;
    assign en_inf       = en_q;
    assign we_inf       = we_q;
    assign addr_inf     = addr_q;
    assign dl_inf       = dl_q;
    assign top_addr_inf = top_q;
    assign inf_start    = start_q;
    assign busy         = busy_q;
    assign full         = full_q;
    assign err_syntax   = err_q;

endmodule

// File: tb/tb_inf_token_writer.sv
// Directed testbench for inf_token_writer with a negedge RAM model.
module tb_inf_token_writer;

    logic        clk;
    logic        rstn;
    logic        tok_valid;
    logic        tok_ready;
    logic        tok_is_op;
    logic [31:0] tok_data;
    logic        tok_commit;
    logic        tok_clear;
    logic        finish;
    logic        en_inf;
    logic        we_inf;
    logic [8:0]  addr_inf;
    logic [35:0] dl_inf;
    logic [8:0]  top_addr_inf;
    logic        inf_start;
    logic        busy;
    logic        full;
    logic        err_syntax;

    int n_cmp;
    int n_err;

    logic [35:0] ram [0:511];
    int          wr_count;
    int          last_addr;
    int          addr0_writes;
    int          err_count;

    inf_token_writer dut (
        .CLK_1MHz     (clk),
        .RSTN         (rstn),
        .tok_valid    (tok_valid),
        .tok_ready    (tok_ready),
        .tok_is_op    (tok_is_op),
        .tok_data     (tok_data),
        .tok_commit   (tok_commit),
        .tok_clear    (tok_clear),
        .finish       (finish),
        .en_inf       (en_inf),
        .we_inf       (we_inf),
        .addr_inf     (addr_inf),
        .dl_inf       (dl_inf),
        .top_addr_inf (top_addr_inf),
        .inf_start    (inf_start),
        .busy         (busy),
        .full         (full),
        .err_syntax   (err_syntax)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM writes on negedge; error pulses are counted on the same edge.
    always @(negedge clk) begin
        if (en_inf === 1'b1 && we_inf === 1'b1) begin
            ram[addr_inf] = dl_inf;
            wr_count      = wr_count + 1;
            last_addr     = int'(addr_inf);
            if (addr_inf == 9'd0) addr0_writes = addr0_writes + 1;
        end
        if (err_syntax === 1'b1) err_count = err_count + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        tok_clear = 1'b1;
        tick();
        tok_clear = 1'b0;
    endtask

    task automatic send_token(input logic op, input logic [31:0] d);
        int n;
        n = 0;
        while (tok_ready !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        n_cmp++;
        if (tok_ready !== 1'b1) begin
            $display("FAIL send_ready: tok_ready=%b required 1", tok_ready);
            n_err++;
        end
        tok_valid = 1'b1;
        tok_is_op = op;
        tok_data  = d;
        tick();
        tok_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rstn       = 1'b0;
        tok_valid  = 1'b0;
        tok_is_op  = 1'b0;
        tok_data   = 32'h0;
        tok_commit = 1'b0;
        tok_clear  = 1'b0;
        finish     = 1'b0;
        repeat (3) tick();
        n_cmp++;
        if ({tok_ready, en_inf, we_inf, addr_inf, dl_inf, top_addr_inf,
             inf_start, busy, full, err_syntax} !== 63'd0) begin
            $display("FAIL reset_outputs: ready=%b en=%b we=%b addr=%h dl=%h top=%h start=%b busy=%b full=%b err=%b required all 0",
                     tok_ready, en_inf, we_inf, addr_inf, dl_inf, top_addr_inf,
                     inf_start, busy, full, err_syntax);
            n_err++;
        end
        rstn = 1'b1;
        tick();
        n_cmp++;
        if (tok_ready !== 1'b1) begin
            $display("FAIL reset_ready: tok_ready=%b required 1", tok_ready);
            n_err++;
        end
    endtask

    task automatic test_expression();
        logic [31:0] td  [0:8];
        logic        top [0:8];
        logic [35:0] exp_w [0:8];
        int wc0;
        int starts;
        td    = '{32'h42613333, 32'h171, 32'h150, 32'h41500000, 32'h170,
                  32'h41000000, 32'h151, 32'h190, 32'h41400000};
        top   = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        exp_w = '{36'h042613333, 36'h100000171, 36'h100000150, 36'h041500000,
                  36'h100000170, 36'h041000000, 36'h100000151, 36'h100000190,
                  36'h041400000};
        wc0 = wr_count;
        for (int i = 0; i < 9; i++) send_token(top[i], td[i]);
        for (int i = 0; i < 9; i++) begin
            n_cmp++;
            if (ram[i+1] !== exp_w[i]) begin
                $display("FAIL expr_ram[%0d]: got %h required %h", i + 1, ram[i+1], exp_w[i]);
                n_err++;
            end
        end
        n_cmp++;
        if (top_addr_inf !== 9'd9 || wr_count - wc0 != 9) begin
            $display("FAIL expr_top: top=%0d writes=%0d required 9/9", top_addr_inf, wr_count - wc0);
            n_err++;
        end
        tok_commit = 1'b1;
        tick();
        tok_commit = 1'b0;
        starts = 0;
        for (int i = 0; i < 6; i++) begin
            if (inf_start === 1'b1) starts++;
            tick();
        end
        n_cmp++;
        if (starts != 2) begin
            $display("FAIL expr_start_len: got %0d cycles required 2", starts);
            n_err++;
        end
        n_cmp++;
        if (busy !== 1'b1 || tok_ready !== 1'b0) begin
            $display("FAIL expr_run: busy=%b ready=%b required 1/0", busy, tok_ready);
            n_err++;
        end
        finish = 1'b1;
        tick();
        finish = 1'b0;
        n_cmp++;
        if (busy !== 1'b0 || top_addr_inf !== 9'd0 || tok_ready !== 1'b1) begin
            $display("FAIL expr_finish: busy=%b top=%0d ready=%b required 0/0/1",
                     busy, top_addr_inf, tok_ready);
            n_err++;
        end
    endtask

    task automatic test_empty_commit();
        int wc0;
        int ec0;
        wc0 = wr_count;
        ec0 = err_count;
        tok_commit = 1'b1;
        tick();
        tok_commit = 1'b0;
        n_cmp++;
        if (err_syntax !== 1'b1 || inf_start !== 1'b0) begin
            $display("FAIL empty_commit_err: err=%b start=%b required 1/0", err_syntax, inf_start);
            n_err++;
        end
        tick();
        tick();
        n_cmp++;
        if (err_count - ec0 != 1 || busy !== 1'b0 || wr_count != wc0) begin
            $display("FAIL empty_commit_after: pulses=%0d busy=%b writes=%0d required 1/0/0",
                     err_count - ec0, busy, wr_count - wc0);
            n_err++;
        end
    endtask

    task automatic test_back_to_back();
        int   wc0;
        int   i;
        int   cyc;
        logic exp_ready;
        logic acc;
        do_clear();
        wc0       = wr_count;
        i         = 0;
        cyc       = 0;
        exp_ready = 1'b1;
        tok_valid = 1'b1;
        tok_is_op = 1'b0;
        tok_data  = 32'hA000_0000;
        while (i < 6 && cyc < 40) begin
            n_cmp++;
            if (tok_ready !== exp_ready) begin
                $display("FAIL b2b_ready cyc%0d: got %b required %b", cyc, tok_ready, exp_ready);
                n_err++;
            end
            acc = tok_ready;
            tick();
            cyc++;
            exp_ready = ~exp_ready;
            if (acc === 1'b1) begin
                i++;
                tok_data = 32'hA000_0000 + 32'(i);
            end
        end
        tok_valid = 1'b0;
        tick();
        n_cmp++;
        if (i != 6 || wr_count - wc0 != 6 || top_addr_inf !== 9'd6) begin
            $display("FAIL b2b_count: taken=%0d writes=%0d top=%0d required 6/6/6",
                     i, wr_count - wc0, top_addr_inf);
            n_err++;
        end
        for (int k = 0; k < 6; k++) begin
            n_cmp++;
            if (ram[k+1] !== (36'h0A0000000 + 36'(k))) begin
                $display("FAIL b2b_ram[%0d]: got %h required %h", k + 1, ram[k+1],
                         36'h0A0000000 + 36'(k));
                n_err++;
            end
        end
        // Token and commit together: token taken, commit dropped.
        tok_valid  = 1'b1;
        tok_commit = 1'b1;
        tok_data   = 32'h0000_0077;
        tick();
        tok_valid  = 1'b0;
        tok_commit = 1'b0;
        tick();
        tick();
        n_cmp++;
        if (top_addr_inf !== 9'd7 || busy !== 1'b0 || inf_start !== 1'b0) begin
            $display("FAIL valid_commit: top=%0d busy=%b start=%b required 7/0/0",
                     top_addr_inf, busy, inf_start);
            n_err++;
        end
    endtask

    task automatic test_full();
        int wc0;
        do_clear();
        for (int i = 1; i <= 511; i++) send_token(1'b0, 32'(i));
        n_cmp++;
        if (full !== 1'b1 || tok_ready !== 1'b0 || top_addr_inf !== 9'd511) begin
            $display("FAIL full_flags: full=%b ready=%b top=%0d required 1/0/511",
                     full, tok_ready, top_addr_inf);
            n_err++;
        end
        n_cmp++;
        if (ram[511] !== 36'h0000001FF) begin
            $display("FAIL full_last_word: got %h required 0000001ff", ram[511]);
            n_err++;
        end
        wc0 = wr_count;
        tok_valid = 1'b1;
        tok_data  = 32'hDEAD_BEEF;
        repeat (4) tick();
        tok_valid = 1'b0;
        tick();
        n_cmp++;
        if (wr_count != wc0 || top_addr_inf !== 9'd511 || full !== 1'b1) begin
            $display("FAIL full_ignore: writes=%0d top=%0d full=%b required 0/511/1",
                     wr_count - wc0, top_addr_inf, full);
            n_err++;
        end
        do_clear();
        n_cmp++;
        if (full !== 1'b0 || top_addr_inf !== 9'd0 || tok_ready !== 1'b1) begin
            $display("FAIL full_clear: full=%b top=%0d ready=%b required 0/0/1",
                     full, top_addr_inf, tok_ready);
            n_err++;
        end
    endtask

    task automatic test_clear();
        do_clear();
        send_token(1'b0, 32'h1111_0001);
        send_token(1'b1, 32'h170);
        send_token(1'b0, 32'h1111_0003);
        n_cmp++;
        if (top_addr_inf !== 9'd3) begin
            $display("FAIL clear_pre_top: got %0d required 3", top_addr_inf);
            n_err++;
        end
        do_clear();
        n_cmp++;
        if (top_addr_inf !== 9'd0) begin
            $display("FAIL clear_top: got %0d required 0", top_addr_inf);
            n_err++;
        end
        send_token(1'b0, 32'h5555_AAAA);
        n_cmp++;
        if (last_addr != 1 || ram[1] !== 36'h05555AAAA || top_addr_inf !== 9'd1) begin
            $display("FAIL clear_next: addr=%0d word=%h top=%0d required 1/05555aaaa/1",
                     last_addr, ram[1], top_addr_inf);
            n_err++;
        end
    endtask

    task automatic test_paren();
        int wc0;
        int ec0;
        int n;
`ifdef PAREN_CHECK_EN
        do_clear();
        wc0 = wr_count;
        send_token(1'b1, 32'h150);
        send_token(1'b1, 32'h150);
        send_token(1'b0, 32'h0000_0005);
        tok_commit = 1'b1;
        tick();
        tok_commit = 1'b0;
        n = 0;
        while (inf_start !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        n_cmp++;
        if (inf_start !== 1'b1) begin
            $display("FAIL paren_start: inf_start=%b required 1 within 40 cycles", inf_start);
            n_err++;
        end
        n_cmp++;
        if (ram[4] !== 36'h100000151 || ram[5] !== 36'h100000151 ||
            top_addr_inf !== 9'd5 || wr_count - wc0 != 5) begin
            $display("FAIL paren_flush: r4=%h r5=%h top=%0d writes=%0d required 100000151 x2/5/5",
                     ram[4], ram[5], top_addr_inf, wr_count - wc0);
            n_err++;
        end
        repeat (3) tick();
        finish = 1'b1;
        tick();
        finish = 1'b0;
        wc0 = wr_count;
        ec0 = err_count;
        send_token(1'b1, 32'h151);
        n_cmp++;
        if (err_count - ec0 != 1 || wr_count != wc0 || top_addr_inf !== 9'd0) begin
            $display("FAIL paren_lead_close: pulses=%0d writes=%0d top=%0d required 1/0/0",
                     err_count - ec0, wr_count - wc0, top_addr_inf);
            n_err++;
        end
`else
        do_clear();
        wc0 = wr_count;
        ec0 = err_count;
        n   = 0;
        send_token(1'b1, 32'h151);
        n_cmp++;
        if (err_count != ec0 || wr_count - wc0 != 1 || ram[1] !== 36'h100000151 ||
            top_addr_inf !== 9'd1 || n != 0) begin
            $display("FAIL paren_verbatim: pulses=%0d writes=%0d word=%h top=%0d required 0/1/100000151/1",
                     err_count - ec0, wr_count - wc0, ram[1], top_addr_inf);
            n_err++;
        end
`endif
    endtask

    task automatic test_reset_in_run();
        do_clear();
        send_token(1'b0, 32'h0000_0042);
        tok_commit = 1'b1;
        tick();
        tok_commit = 1'b0;
        repeat (4) tick();
        n_cmp++;
        if (busy !== 1'b1 || inf_start !== 1'b0) begin
            $display("FAIL run_before_reset: busy=%b start=%b required 1/0", busy, inf_start);
            n_err++;
        end
        #2;
        rstn = 1'b0;
        #1;
        n_cmp++;
        if (busy !== 1'b0 || inf_start !== 1'b0 || top_addr_inf !== 9'd0 || tok_ready !== 1'b0) begin
            $display("FAIL run_reset: busy=%b start=%b top=%0d ready=%b required 0/0/0/0",
                     busy, inf_start, top_addr_inf, tok_ready);
            n_err++;
        end
        tick();
        rstn = 1'b1;
        tick();
    endtask

    initial begin
        n_cmp        = 0;
        n_err        = 0;
        wr_count     = 0;
        last_addr    = -1;
        addr0_writes = 0;
        err_count    = 0;
        test_reset();
        test_expression();
        test_empty_commit();
        test_back_to_back();
        test_full();
        test_clear();
        test_paren();
        test_reset_in_run();
        n_cmp++;
        if (addr0_writes != 0) begin
            $display("FAIL addr0_never_written: got %0d writes required 0", addr0_writes);
            n_err++;
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
